// File: rtl/mesi_bus_sequencer_pkg.sv
// Shared encodings for the MESI bus sequencer: line states, commands,
// bus operations, snoop results and the sequencer FSM states.
package mesi_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [3:0] {
    CMD_L1_RD   = 4'd0,
    CMD_L1_WR   = 4'd1,
    CMD_L1_IRD  = 4'd2,
    CMD_SNP_INV = 4'd3,
    CMD_SNP_RD  = 4'd4,
    CMD_SNP_WR  = 4'd5,
    CMD_SNP_RFO = 4'd6
  } cmd_e;

  localparam logic [3:0] CMD_LAST_LEGAL = 4'd6;

  typedef enum logic [2:0] {
    BUSOP_NONE  = 3'd0,
    BUSOP_READ  = 3'd1,
    BUSOP_WRITE = 3'd2,
    BUSOP_INV   = 3'd3,
    BUSOP_RFO   = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'd0,
    SNOOP_HIT   = 2'd1,
    SNOOP_HITM  = 2'd2
  } snoop_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_BUS    = 2'd2,
    ST_UPDATE = 2'd3
  } seq_state_e;

  // The reserved snoop code 3 behaves exactly like a miss.
  function automatic snoop_e normSnoop(input logic [1:0] raw);
    return (raw == 2'd3) ? SNOOP_NOHIT : snoop_e'(raw);
  endfunction

endpackage

// File: rtl/mesi_bus_sequencer_if.sv
// Request, bus, tag-write and response signals of the MESI bus sequencer.
interface mesi_bus_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_state;

  logic              bus_valid;
  logic [2:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic [1:0]        bus_snoop;

  logic              state_we;
  logic [ADDR_W-1:0] state_wr_addr;
  logic [1:0]        state_wr_data;

  logic              resp_valid;
  logic              resp_err;
  logic              resp_timeout;

  modport master (
    input  req_valid, req_cmd, req_addr, req_state, bus_ack, bus_snoop,
    output req_ready, bus_valid, bus_op, bus_addr,
           state_we, state_wr_addr, state_wr_data,
           resp_valid, resp_err, resp_timeout
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_state, bus_ack, bus_snoop,
    input  req_ready, bus_valid, bus_op, bus_addr,
           state_we, state_wr_addr, state_wr_data,
           resp_valid, resp_err, resp_timeout
  );
endinterface

// File: rtl/mesi_bus_sequencer_nsl.sv
// Combinational MESI transition table: next state, required bus operation
// and illegal-combination flag for a present state, command and snoop result.
module mesi_next_state_logic
  import mesi_bus_sequencer_pkg::*;
(
  input  mesi_e      pres_i,
  input  logic [3:0] cmd_i,
  input  snoop_e     snoop_i,
  output mesi_e      next_o,
  output bus_op_e    busOp_o,
  output logic       illegal_o
);

  logic snoopHit;
  assign snoopHit = (snoop_i == SNOOP_HIT) || (snoop_i == SNOOP_HITM);

  always_comb begin
    next_o    = pres_i;
    busOp_o   = BUSOP_NONE;
    illegal_o = 1'b0;

    if (cmd_i > CMD_LAST_LEGAL) begin
      illegal_o = 1'b1;
    end else begin
      unique case (pres_i)
        MESI_M: begin
          unique case (cmd_e'(cmd_i))
            CMD_SNP_RD:  begin next_o = MESI_S; busOp_o = BUSOP_WRITE; end
            CMD_SNP_RFO: begin next_o = MESI_I; busOp_o = BUSOP_WRITE; end
            CMD_SNP_WR, CMD_SNP_INV: illegal_o = 1'b1;
            default: ;
          endcase
        end
        MESI_E: begin
          unique case (cmd_e'(cmd_i))
            CMD_SNP_RD:  next_o = MESI_S;
            CMD_SNP_RFO: next_o = MESI_I;
            CMD_L1_WR:   next_o = MESI_M;
            CMD_SNP_WR, CMD_SNP_INV: illegal_o = 1'b1;
            default: ;
          endcase
        end
        MESI_S: begin
          unique case (cmd_e'(cmd_i))
            CMD_SNP_INV, CMD_SNP_RFO: next_o = MESI_I;
            CMD_L1_WR:  begin next_o = MESI_M; busOp_o = BUSOP_INV; end
            CMD_SNP_WR: illegal_o = 1'b1;
            default: ;
          endcase
        end
        default: begin
          // A read miss lands in Shared if any other cache holds the line.
          unique case (cmd_e'(cmd_i))
            CMD_L1_RD, CMD_L1_IRD: begin
              next_o  = snoopHit ? MESI_S : MESI_E;
              busOp_o = BUSOP_READ;
            end
            CMD_L1_WR: begin next_o = MESI_M; busOp_o = BUSOP_RFO; end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/mesi_bus_sequencer.sv
// Sequences one MESI coherence transaction at a time: evaluate, optional bus
// operation with timeout, then tag-array state write-back and response.
module mesi_bus_sequencer
  import mesi_bus_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BUS_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mesi_bus_sequencer_if.master bus
);

  localparam int                CNT_W    = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mesi_e             pres_q, pres_d;
  snoop_e            snoop_q, snoop_d;
  bus_op_e           busOp_q, busOp_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  snoop_e  nslSnoop;
  mesi_e   nslNext;
  bus_op_e nslBusOp;
  logic    nslIllegal;

  // EVAL only needs the bus op, so it sees a miss; UPDATE uses the real snoop.
  assign nslSnoop = (state_q == ST_UPDATE) ? snoop_q : SNOOP_NOHIT;

  mesi_next_state_logic u_nsl (
    .pres_i    (pres_q),
    .cmd_i     (cmd_q),
    .snoop_i   (nslSnoop),
    .next_o    (nslNext),
    .busOp_o   (nslBusOp),
    .illegal_o (nslIllegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      pres_q  <= MESI_I;
      snoop_q <= SNOOP_NOHIT;
      busOp_q <= BUSOP_NONE;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      pres_q  <= pres_d;
      snoop_q <= snoop_d;
      busOp_q <= busOp_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    pres_d  = pres_q;
    snoop_d = snoop_q;
    busOp_d = busOp_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;

    bus.req_ready     = 1'b0;
    bus.bus_valid     = 1'b0;
    bus.bus_op        = '0;
    bus.bus_addr      = '0;
    bus.state_we      = 1'b0;
    bus.state_wr_addr = '0;
    bus.state_wr_data = '0;
    bus.resp_valid    = 1'b0;
    bus.resp_err      = 1'b0;
    bus.resp_timeout  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cmd_d   = bus.req_cmd;
          addr_d  = bus.req_addr;
          pres_d  = mesi_e'(bus.req_state);
          snoop_d = SNOOP_NOHIT;
          busOp_d = BUSOP_NONE;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        if (nslIllegal) begin
          err_d   = 1'b1;
          state_d = ST_UPDATE;
        end else if (nslBusOp == BUSOP_NONE) begin
          state_d = ST_UPDATE;
        end else begin
          busOp_d = nslBusOp;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        bus.bus_valid = 1'b1;
        bus.bus_op    = busOp_q;
        bus.bus_addr  = addr_q;
        if (bus.bus_ack) begin
          snoop_d = normSnoop(bus.bus_snoop);
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        bus.resp_valid   = 1'b1;
        bus.resp_err     = err_q;
        bus.resp_timeout = tmo_q;
        if (!err_q && !tmo_q) begin
          bus.state_we      = 1'b1;
          bus.state_wr_addr = addr_q;
          bus.state_wr_data = nslNext;
        end
        busOp_d = BUSOP_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
